// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Owns the shared N-bit ALU for one requester. A request is accepted with a
//   valid/ready handshake while idle. A single-cycle op (AND/ORR/ADD/SUB/PASSB/NOR)
//   makes one ALU pass. MUL (4'b1000) is done as N shift-and-add passes of the
//   ALU's ADD. Any other op is answered at once with an error response. The result
//   is held on a valid/ready response port until it is consumed.
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   req_valid/req_ready     request handshake (ready only while idle)
//   req_op/req_a/req_b      operation code and operands, latched on accept
//   rsp_valid/rsp_ready     response handshake
//   rsp_data/rsp_z/rsp_err  result, result==0, illegal-op flag (registered)
//   busy                    sequencer not idle (registered)
//   alu_in1/alu_in2/alu_op  drive the ALU (combinational from the state)
//   alu_out/alu_z           ALU result and zero flag (combinational ALU)
module alu_op_sequencer #(
    parameter int N = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic [3:0]   req_op,
    input  logic [N-1:0] req_a,
    input  logic [N-1:0] req_b,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic [N-1:0] rsp_data,
    output logic         rsp_z,
    output logic         rsp_err,
    output logic         busy,
    output logic [N-1:0] alu_in1,
    output logic [N-1:0] alu_in2,
    output logic [3:0]   alu_op,
    input  logic [N-1:0] alu_out,
    input  logic         alu_z
);

    localparam int              CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0]   CNT_LAST = CW'(N - 1);
    localparam logic [3:0]      OP_ADD   = 4'b0010;
    localparam logic [3:0]      OP_MUL   = 4'b1000;

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    state_t       state, state_nxt;
    logic [3:0]   op_r;
    logic [N-1:0] a_r;      // operand A; doubles as the shifting multiplicand
    logic [N-1:0] b_r;      // operand B; doubles as the shifting multiplier
    logic [N-1:0] acc;
    logic [CW-1:0] cnt;
    logic         accept;
    logic         op_single;
    logic         op_mul;

    assign accept = req_valid && (state == S_IDLE);
    assign op_mul = (req_op == OP_MUL);

    always_comb begin
        op_single = 1'b0;
        case (req_op)
            4'b0000, 4'b0001, 4'b0010,
            4'b0110, 4'b0111, 4'b1100: op_single = 1'b1;
            default:                   op_single = 1'b0;
        endcase
    end

    // Next state and ALU drive. Outside EXEC/MUL the ALU sees 0 + 0 so its
    // inputs never toggle with stale operands.
    always_comb begin
        state_nxt = state;
        alu_in1   = '0;
        alu_in2   = '0;
        alu_op    = OP_ADD;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (op_single)   state_nxt = S_EXEC;
                    else if (op_mul) state_nxt = S_MUL;
                    else             state_nxt = S_RESP;
                end
            end
            S_EXEC: begin
                alu_in1   = a_r;
                alu_in2   = b_r;
                alu_op    = op_r;
                state_nxt = S_RESP;
            end
            S_MUL: begin
                // Add the shifted multiplicand only when the current multiplier bit is set.
                alu_in1 = acc;
                alu_in2 = b_r[0] ? a_r : '0;
                if (cnt == CNT_LAST) state_nxt = S_RESP;
            end
            S_RESP: begin
                if (rsp_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            busy      <= 1'b0;
            rsp_data  <= '0;
            rsp_z     <= 1'b0;
            rsp_err   <= 1'b0;
            op_r      <= '0;
            a_r       <= '0;
            b_r       <= '0;
            acc       <= '0;
            cnt       <= '0;
        end else begin
            state     <= state_nxt;
            // Handshake/status flags are flopped from the next state so they
            // come straight out of registers.
            req_ready <= (state_nxt == S_IDLE);
            rsp_valid <= (state_nxt == S_RESP);
            busy      <= (state_nxt != S_IDLE);
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op_r <= req_op;
                        a_r  <= req_a;
                        b_r  <= req_b;
                        acc  <= '0;
                        cnt  <= '0;
                        if (!op_single && !op_mul) begin
                            rsp_data <= '0;
                            rsp_z    <= 1'b1;
                            rsp_err  <= 1'b1;
                        end
                    end
                end
                S_EXEC: begin
                    rsp_data <= alu_out;
                    rsp_z    <= alu_z;
                    rsp_err  <= 1'b0;
                end
                S_MUL: begin
                    acc <= alu_out;
                    a_r <= a_r << 1;
                    b_r <= b_r >> 1;
                    cnt <= cnt + 1'b1;
                    if (cnt == CNT_LAST) begin
                        rsp_data <= alu_out;
                        rsp_z    <= alu_z;
                        rsp_err  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
